// File: rtl/score_display_pkg.sv
// score_display_pkg: shared constants for the score display path.
// Active-low 7-segment glyphs {g,f,e,d,c,b,a}, blank code, FSM states.
package score_display_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] GLYPH_0 = 7'h40;
   localparam logic [6:0] GLYPH_1 = 7'h79;
   localparam logic [6:0] GLYPH_2 = 7'h24;
   localparam logic [6:0] GLYPH_3 = 7'h30;
   localparam logic [6:0] GLYPH_4 = 7'h19;
   localparam logic [6:0] GLYPH_5 = 7'h12;
   localparam logic [6:0] GLYPH_6 = 7'h02;
   localparam logic [6:0] GLYPH_7 = 7'h78;
   localparam logic [6:0] GLYPH_8 = 7'h00;
   localparam logic [6:0] GLYPH_9 = 7'h10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/score_display_seg7_decode.sv
// seg7_decode: combinational BCD nibble to active-low segments.
// Ports: bcd (4-bit digit in), seg (7-bit {g..a} out); 10-15 blank.
module seg7_decode
   import score_display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      unique case (bcd)
         4'd0:    seg = GLYPH_0;
         4'd1:    seg = GLYPH_1;
         4'd2:    seg = GLYPH_2;
         4'd3:    seg = GLYPH_3;
         4'd4:    seg = GLYPH_4;
         4'd5:    seg = GLYPH_5;
         4'd6:    seg = GLYPH_6;
         4'd7:    seg = GLYPH_7;
         4'd8:    seg = GLYPH_8;
         4'd9:    seg = GLYPH_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/score_display.sv
// score_display: score/high-score to BCD (double dabble) to muxed 7-seg.
// Ports: clk, reset(async low), score, game_over, show_high -> seg, an, busy.
module score_display
   import score_display_pkg::*;
#(
   parameter int SCORE_W  = 16,
   parameter int DIGITS   = 5,
   parameter int SCAN_DIV = 1024
)(
   input  logic               clk,
   input  logic               reset,
   input  logic [SCORE_W-1:0] score,
   input  logic               game_over,
   input  logic               show_high,
   output logic [6:0]         seg,
   output logic [DIGITS-1:0]  an,
   output logic               busy
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int IT_W  = $clog2(SCORE_W + 1);
   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [SCORE_W-1:0] hi, last_src, bin, src;
   logic               go_q;
   logic [BCD_W-1:0]   bcd, bcd_adj, disp_bcd;
   logic [IT_W-1:0]    iter;
   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [IDX_W-1:0]   idx;
   logic [DIGITS-1:0]  blank;
   logic               zero_hi;
   logic [3:0]         nib;
   logic               nib_blank;
   logic [6:0]         glyph;

   assign src = show_high ? hi : score;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi   <= '0;
         go_q <= 1'b0;
      end else begin
         go_q <= game_over;
         if (game_over && !go_q && score > hi)
            hi <= score;
      end
   end

   always_comb begin
      bcd_adj = bcd;
      for (int k = 0; k < DIGITS; k++)
         if (bcd[4*k +: 4] >= 4'd5)
            bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         bin      <= '0;
         bcd      <= '0;
         last_src <= '0;
         iter     <= '0;
         busy     <= 1'b0;
         disp_bcd <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (src != last_src) begin
                  bin      <= src;
                  bcd      <= '0;
                  last_src <= src;
                  iter     <= '0;
                  busy     <= 1'b1;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               bcd  <= {bcd_adj[BCD_W-2:0], bin[SCORE_W-1]};
               bin  <= {bin[SCORE_W-2:0], 1'b0};
               iter <= iter + 1'b1;
               if (iter == IT_W'(SCORE_W - 1))
                  state <= DONE;
            end
            DONE: begin
               disp_bcd <= bcd;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Digit k is blank when it and every digit above it are zero;
   // the ones digit is never blanked so 0 still shows.
   always_comb begin
      blank   = '0;
      zero_hi = 1'b1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         zero_hi  = zero_hi && (disp_bcd[4*k +: 4] == 4'd0);
         blank[k] = zero_hi && (k != 0);
      end
   end

   always_comb begin
      nib       = '0;
      nib_blank = 1'b1;
      for (int k = 0; k < DIGITS; k++)
         if (idx == IDX_W'(k)) begin
            nib       = disp_bcd[4*k +: 4];
            nib_blank = blank[k];
         end
   end

   seg7_decode u_dec (
      .bcd (nib),
      .seg (glyph)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
         idx <= '0;
         seg <= SEG_BLANK;
         an  <= '1;
      end else begin
         if (cnt == CNT_W'(SCAN_DIV - 1)) begin
            cnt <= '0;
            idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
         an  <= ~(DIGITS'(1) << idx);
         seg <= nib_blank ? SEG_BLANK : glyph;
      end
   end

endmodule

// File: tb/tb_score_display.sv
// tb_score_display: scoreboarded directed bench for score_display.
// Conversions are checked on busy falling; display/scan checked on pins.
module tb_score_display;

   logic        clk;
   logic        reset;
   logic [15:0] score;
   logic        game_over;
   logic        show_high;
   logic [6:0]  seg;
   logic [4:0]  an;
   logic        busy;

   int cmp  = 0;
   int errs = 0;
   int done_cnt = 0;
   logic [19:0] sb[$];
   logic [6:0]  gl [10];

   score_display #(
      .SCORE_W  (16),
      .DIGITS   (5),
      .SCAN_DIV (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .score     (score),
      .game_over (game_over),
      .show_high (show_high),
      .seg       (seg),
      .an        (an),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: a completed conversion shows as busy falling.
   initial begin
      logic busy_q;
      logic [19:0] exp;
      busy_q = 1'b0;
      forever begin
         @(negedge clk);
         if (reset && busy_q && !busy) begin
            done_cnt++;
            cmp++;
            if (sb.size() == 0) begin
               errs++;
               $display("FAIL conv_unexpected got %h want none",
                        dut.disp_bcd);
            end else begin
               exp = sb.pop_front();
               if (dut.disp_bcd !== exp) begin
                  errs++;
                  $display("FAIL conv got %h want %h",
                           dut.disp_bcd, exp);
               end
            end
         end
         busy_q = busy;
      end
   end

   task automatic chk(input string nm, input int act, input int req);
      cmp++;
      if (act != req) begin
         errs++;
         $display("FAIL %s got %0d want %0d", nm, act, req);
      end
   endtask

   task automatic wait_conv(input int n);
      int tgt;
      int k;
      tgt = done_cnt + n;
      k = 0;
      while (done_cnt < tgt && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (done_cnt < tgt) begin
         cmp++;
         errs++;
         $display("FAIL wait_conv got %0d want %0d", done_cnt, tgt);
      end
   endtask

   task automatic check_display(input int v);
      int pw;
      int d;
      int k2;
      logic [4:0] tgt;
      logic [6:0] exp;
      pw = 1;
      for (int k = 0; k < 5; k++) begin
         d = (v / pw) % 10;
         exp = (k != 0 && v < pw) ? 7'h7F : gl[d];
         tgt = ~(5'b00001 << k);
         k2 = 0;
         while (an !== tgt && k2 < 50) begin
            @(negedge clk);
            k2++;
         end
         cmp++;
         if (an !== tgt || seg !== exp) begin
            errs++;
            $display("FAIL disp v=%0d dig%0d got an=%b seg=%h want an=%b seg=%h",
                     v, k, an, seg, tgt, exp);
         end
         pw = pw * 10;
      end
   endtask

   initial begin
      int n;
      logic [4:0] cur;
      gl[0] = 7'h40; gl[1] = 7'h79; gl[2] = 7'h24; gl[3] = 7'h30;
      gl[4] = 7'h19; gl[5] = 7'h12; gl[6] = 7'h02; gl[7] = 7'h78;
      gl[8] = 7'h00; gl[9] = 7'h10;

      reset = 1'b0;
      score = '0;
      game_over = 1'b0;
      show_high = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_seg", int'(seg), 'h7F);
      chk("rst_an", int'(an), 'h1F);
      chk("rst_busy", int'(busy), 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // 1: reset mid-SHIFT aborts, then converges after 18 cycles
      score = 16'd1234;
      repeat (6) @(negedge clk);
      chk("mid_busy", int'(busy), 1);
      reset = 1'b0;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_seg", int'(seg), 'h7F);
      chk("abort_an", int'(an), 'h1F);
      chk("abort_disp", int'(dut.disp_bcd), 0);
      @(negedge clk);
      reset = 1'b1;
      sb.push_back(20'h01234);
      n = 0;
      while (dut.disp_bcd !== 20'h01234 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("lat_1234", n, 18);
      @(negedge clk);
      check_display(1234);

      // 0 shows a single digit
      score = 16'd0;
      sb.push_back(20'h00000);
      wait_conv(1);
      check_display(0);

      // 2: full-scale value, busy width
      @(negedge clk);
      score = 16'd65535;
      sb.push_back(20'h65535);
      n = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (busy) n++;
         else if (n > 0) break;
      end
      chk("busy_len", n, 17);
      check_display(65535);

      // 3: leading-zero blanking
      score = 16'd7;
      sb.push_back(20'h00007);
      wait_conv(1);
      check_display(7);

      // 4: high score commits on rise only when larger
      score = 16'd100;
      sb.push_back(20'h00100);
      wait_conv(1);
      game_over = 1'b1;
      @(negedge clk);
      game_over = 1'b0;
      @(negedge clk);
      score = 16'd50;
      sb.push_back(20'h00050);
      wait_conv(1);
      game_over = 1'b1;
      @(negedge clk);
      game_over = 1'b0;
      @(negedge clk);
      show_high = 1'b1;
      sb.push_back(20'h00100);
      n = 0;
      while (dut.disp_bcd !== 20'h00100 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("hi_lat", n, 18);
      @(negedge clk);
      check_display(100);
      show_high = 1'b0;
      sb.push_back(20'h00050);
      wait_conv(1);

      // 5: changes during SHIFT ignored, then converges
      @(negedge clk);
      score = 16'd5;
      sb.push_back(20'h00005);
      sb.push_back(20'h00012);
      @(negedge clk);
      score = 16'd9;
      @(negedge clk);
      score = 16'd12;
      wait_conv(2);
      check_display(12);

      // 6: anode scan order and dwell
      n = 0;
      cur = an;
      while (!(an === 5'b11110 && cur === 5'b01111) && n < 100) begin
         cur = an;
         @(negedge clk);
         n++;
      end
      chk("scan_sync", int'(an), 'h1E);
      for (int p = 0; p < 10; p++) begin
         cur = an;
         n = 1;
         forever begin
            @(negedge clk);
            if (an !== cur || n > 50) break;
            n++;
         end
         chk("scan_an", int'(cur), int'(~(5'b00001 << (p % 5)) & 5'h1F));
         chk("scan_len", n, 4);
      end

      chk("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end

endmodule
